// File: rtl/bus_pkg.sv
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Shared address map, STATUS bit positions and TX state encoding
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam logic [13:0] c_io_base      = 14'h3F00;
    localparam logic [13:0] c_addr_led     = 14'h3F00;
    localparam logic [13:0] c_addr_cycles  = 14'h3F01;
    localparam logic [13:0] c_addr_txdata  = 14'h3F02;
    localparam logic [13:0] c_addr_status  = 14'h3F03;
    localparam logic [13:0] c_addr_bauddiv = 14'h3F04;

    localparam int c_stat_full  = 0;
    localparam int c_stat_empty = 1;
    localparam int c_stat_busy  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic is_ram_addr(input logic [13:0] addr);
        return addr < c_io_base;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module   : uart_tx
//  Purpose  : Byte FIFO feeding an 8N1 serializer with programmable bit time
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx
    import bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic [15:0] baud_div,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        tx_busy,
    output logic        txd
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               do_push;
    logic               do_pop;

    tx_state_e          state_q;
    logic [15:0]        baud_cnt_q;
    logic [15:0]        div_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               txd_q;
    logic               bit_done;

    assign fifo_full  = (count_q == c_cnt_w'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign bit_done   = (baud_cnt_q == div_q);
    assign tx_busy    = (state_q != TX_IDLE);
    assign txd        = txd_q;

    // The next byte is taken either from idle or exactly at the end of a stop bit.
    always_comb begin
        do_push  = push && !fifo_full;
        do_pop   = !fifo_empty &&
                   ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_done));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // div_q is re-sampled at every bit boundary so divisor changes never split a bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            txd_q      <= 1'b1;
            baud_cnt_q <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (do_pop) begin
                        state_q    <= TX_START;
                        txd_q      <= 1'b0;
                        shift_q    <= mem_q[rd_ptr_q];
                        baud_cnt_q <= '0;
                        div_q      <= baud_div;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        state_q    <= TX_DATA;
                        txd_q      <= shift_q[0];
                        bit_idx_q  <= '0;
                        baud_cnt_q <= '0;
                        div_q      <= baud_div;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        div_q      <= baud_div;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= TX_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        div_q      <= baud_div;
                        if (do_pop) begin
                            state_q <= TX_START;
                            txd_q   <= 1'b0;
                            shift_q <= mem_q[rd_ptr_q];
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_bus_bridge.sv
// ============================================================================
//  Module   : data_bus_bridge
//  Purpose  : CPU data bus decode to RAM and memory-mapped LED/CYCLES/UART I/O
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_bus_bridge
    import bus_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic [13:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic [7:0]  led,
    output logic        uart_txd
);

    logic        is_ram;
    logic        io_wr;
    logic        tx_push;
    logic        fifo_full;
    logic        fifo_empty;
    logic        tx_busy;

    logic [7:0]  led_q, led_d;
    logic [31:0] cycles_q, cycles_d;
    logic [15:0] baud_div_q, baud_div_d;
    logic [31:0] io_rdata_q, io_rdata_d;
    logic        sel_io_q, sel_io_d;

    assign is_ram    = is_ram_addr(cpu_addr);
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_we && is_ram;
    assign io_wr     = cpu_we && !is_ram;
    assign tx_push   = io_wr && (cpu_addr == c_addr_txdata);
    assign led       = led_q;

    // Select and I/O value are captured on the same edge the RAM latches its address.
    assign cpu_rdata = sel_io_q ? io_rdata_q : ram_rdata;

    always_comb begin
        led_d      = led_q;
        baud_div_d = baud_div_q;
        cycles_d   = cycles_q + 32'd1;
        if (io_wr) begin
            case (cpu_addr)
                c_addr_led:     led_d      = cpu_wdata[7:0];
                c_addr_cycles:  cycles_d   = '0;
                c_addr_bauddiv: baud_div_d = cpu_wdata[15:0];
                default:        ;
            endcase
        end

        sel_io_d   = !is_ram;
        io_rdata_d = '0;
        case (cpu_addr)
            c_addr_led:     io_rdata_d = {24'd0, led_q};
            c_addr_cycles:  io_rdata_d = cycles_q;
            c_addr_status: begin
                io_rdata_d[c_stat_full]  = fifo_full;
                io_rdata_d[c_stat_empty] = fifo_empty;
                io_rdata_d[c_stat_busy]  = tx_busy;
            end
            c_addr_bauddiv: io_rdata_d = {16'd0, baud_div_q};
            default:        io_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= '0;
            cycles_q   <= '0;
            baud_div_q <= DIV_RESET;
            io_rdata_q <= '0;
            sel_io_q   <= 1'b0;
        end else begin
            led_q      <= led_d;
            cycles_q   <= cycles_d;
            baud_div_q <= baud_div_d;
            io_rdata_q <= io_rdata_d;
            sel_io_q   <= sel_io_d;
        end
    end

    uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_uart_tx (
        .clk        (clk),
        .rst        (rst),
        .push       (tx_push),
        .push_data  (cpu_wdata[7:0]),
        .baud_div   (baud_div_q),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .tx_busy    (tx_busy),
        .txd        (uart_txd)
    );

endmodule

`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
// ============================================================================
//  Module   : tb_data_bus_bridge
//  Purpose  : Randomized self-checking bench for data_bus_bridge
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_bus_bridge;

    localparam logic [13:0] c_a_led     = 14'h3F00;
    localparam logic [13:0] c_a_cycles  = 14'h3F01;
    localparam logic [13:0] c_a_txdata  = 14'h3F02;
    localparam logic [13:0] c_a_status  = 14'h3F03;
    localparam logic [13:0] c_a_bauddiv = 14'h3F04;
    localparam logic [13:0] c_a_io_base = 14'h3F00;
    localparam int          c_log_n     = 8192;
    localparam int          c_never     = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [7:0]  led;
    logic        uart_txd;

    logic [31:0] ram_mem [0:16383];
    logic        txd_log [0:c_log_n-1];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] exp_mem [int];
    logic [7:0]  exp_q [$];
    int          div_old, div_new, div_w;

    data_bus_bridge #(
        .FIFO_DEPTH (4),
        .DIV_RESET  (16'd434)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .led       (led),
        .uart_txd  (uart_txd)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM and edge counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // txd_log[n] holds the line level after rising edge n
    always @(negedge clk) begin
        if (cyc < c_log_n) txd_log[cyc] <= uart_txd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [13:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        #1;
        chk("ram_we", {31'd0, ram_we}, {31'd0, (a < c_a_io_base)});
        chk("ram_addr", {18'd0, ram_addr}, {18'd0, a});
        chk("ram_wdata", ram_wdata, d);
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic load(input logic [13:0] a, output logic [31:0] v);
        cpu_addr = a;
        cpu_we   = 1'b0;
        @(negedge clk);
        v = cpu_rdata;
    endtask

    task automatic idle(input int n);
        cpu_we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Frames are rebuilt from the queued bytes: start 0, 8 data LSB first, stop 1.
    task automatic check_stream(input int start, input string tag);
        int         t;
        int         d;
        int         glitch;
        int         zeros;
        logic [7:0] b;
        logic [9:0] frame;
        logic [9:0] obs;
        t = start;
        while (exp_q.size() > 0) begin
            b      = exp_q.pop_front();
            frame  = {1'b1, b, 1'b0};
            obs    = '0;
            glitch = 0;
            for (int k = 0; k < 10; k++) begin
                d      = (div_w < t) ? div_new : div_old;
                obs[k] = txd_log[t];
                for (int c = 0; c <= d; c++) begin
                    if (txd_log[t + c] !== frame[k]) glitch++;
                end
                t = t + d + 1;
            end
            chk({tag, "_frame"}, {22'd0, obs}, {22'd0, frame});
            chk({tag, "_bitlen"}, 32'(glitch), 32'd0);
        end
        zeros = 0;
        for (int c = 0; c < 8; c++) begin
            if (txd_log[t + c] !== 1'b1) zeros++;
        end
        chk({tag, "_idle_after"}, 32'(zeros), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [13:0] a;
        logic [31:0] d;
        logic [13:0] addrs [$];
        int          p;
        int          n;
        int          dv;
        int          busy;
        int          zeros;
        int          from;

        div_old = 434;
        div_new = 434;
        div_w   = c_never;

        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", {24'd0, led}, 32'd0);
        chk("rst_txd", {31'd0, uart_txd}, 32'd1);
        store(14'h0123, 32'hCAFE_0001);
        rst = 1'b0;

        load(c_a_cycles, v);  chk("rst_cycles", v, 32'd0);
        load(c_a_status, v);  chk("rst_status", v, 32'h2);
        load(c_a_bauddiv, v); chk("rst_bauddiv", v, 32'd434);
        load(c_a_led, v);     chk("rst_led_rd", v, 32'd0);
        load(c_a_txdata, v);  chk("txdata_rd", v, 32'd0);
        load(14'h0123, v);    chk("ram_in_rst", v, 32'hCAFE_0001);

        store(14'h0010, 32'hDEAD_BEEF);
        load(14'h0010, v);    chk("ram_deadbeef", v, 32'hDEAD_BEEF);

        addrs.push_back(14'h3EFF);
        exp_mem[14'h3EFF] = 32'h0;
        for (int i = 0; i < 16; i++) addrs.push_back(14'($urandom_range(0, 14'h3EFE)));
        foreach (addrs[i]) begin
            d = $urandom;
            store(addrs[i], d);
            exp_mem[addrs[i]] = d;
        end
        foreach (addrs[i]) begin
            load(addrs[i], v);
            chk("ram_rd", v, exp_mem[addrs[i]]);
        end

        store(c_a_led, 32'h0000_01A5);
        chk("led_a5", {24'd0, led}, 32'hA5);
        load(c_a_led, v);     chk("led_rd_a5", v, 32'h0000_00A5);
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            store(c_a_led, d);
            load(c_a_led, v);
            chk("led_rd", v, {24'd0, d[7:0]});
            chk("led_out", {24'd0, led}, {24'd0, d[7:0]});
        end

        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 14'h3F05 : 14'($urandom_range(14'h3F05, 14'h3FFF));
            store(a, $urandom);
            load(a, v);
            chk("unmapped_rd", v, 32'd0);
        end

        store(c_a_bauddiv, 32'hFFFF_1234);
        load(c_a_bauddiv, v); chk("bauddiv_rd", v, 32'h0000_1234);

        for (int i = 0; i < 5; i++) begin
            n = (i == 0) ? 3 : $urandom_range(1, 20);
            store(c_a_cycles, $urandom);
            idle(n - 1);
            load(c_a_cycles, v);
            chk("cycles_count", v, 32'(n - 1));
        end

        force dut.cycles_q = 32'hFFFF_FFFF;
        #1;
        chk("cycles_wrap_next", dut.cycles_d, 32'd0);
        load(c_a_cycles, v);  chk("cycles_forced_rd", v, 32'hFFFF_FFFF);
        release dut.cycles_q;
        store(c_a_cycles, 32'd0);

        // Single 0x55 frame at BAUDDIV=3 with STATUS polled every cycle
        store(c_a_bauddiv, 32'd3);
        div_old = 3;
        div_w   = c_never;
        p = cyc + 1;
        store(c_a_txdata, 32'h55);
        busy = 0;
        for (int i = 0; i < 60; i++) begin
            load(c_a_status, v);
            busy += int'(v[2]);
        end
        chk("busy_cycles", 32'(busy), 32'd40);
        exp_q.push_back(8'h55);
        check_stream(p + 1, "b55");

        // Five back-to-back pushes plus one that must be dropped
        p = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            store(c_a_txdata, d);
            exp_q.push_back(d[7:0]);
        end
        store(c_a_txdata, 32'hFF);
        load(c_a_status, v);  chk("status_full", v, 32'h5);
        idle(5 * 40 + 20);
        check_stream(p + 1, "b2b");
        load(c_a_status, v);  chk("status_drained", v, 32'h2);

        for (int it = 0; it < 6; it++) begin
            dv = (it == 0) ? 0 : $urandom_range(0, 2);
            store(c_a_bauddiv, 32'(dv));
            div_old = dv;
            n = $urandom_range(1, 3);
            p = cyc + 1;
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                store(c_a_txdata, d);
                exp_q.push_back(d[7:0]);
            end
            idle(n * 10 * (dv + 1) + 12);
            check_stream(p + 1, "rnd");
        end

        // Divisor rewritten in the middle of data bit 1
        store(c_a_bauddiv, 32'd3);
        div_old = 3;
        p = cyc + 1;
        d = $urandom;
        store(c_a_txdata, d);
        exp_q.push_back(d[7:0]);
        idle(9);
        div_w   = cyc + 1;
        div_new = 1;
        store(c_a_bauddiv, 32'd1);
        idle(40);
        check_stream(p + 1, "divchg");
        div_w   = c_never;
        div_old = 1;

        // Reset in the middle of a frame with a second byte queued
        store(c_a_bauddiv, 32'd3);
        store(c_a_txdata, $urandom);
        store(c_a_txdata, $urandom);
        idle(10);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_txd", {31'd0, uart_txd}, 32'd1);
        rst = 1'b0;
        load(c_a_status, v);  chk("midrst_status", v, 32'h2);
        load(c_a_bauddiv, v); chk("midrst_bauddiv", v, 32'd434);
        load(c_a_led, v);     chk("midrst_led", v, 32'd0);
        from = cyc;
        idle(50);
        zeros = 0;
        for (int c = from; c < from + 45; c++) begin
            if (txd_log[c] !== 1'b1) zeros++;
        end
        chk("midrst_line_idle", 32'(zeros), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
